uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter and sequencer that shares a single `uart_tx` transmitter among `N_REQ` byte requesters. It sits between the requesting blocks and the transmitter's `data`/`send`/`ready` interface. It captures the winning requester's byte and drives the `send` handshake, tracking the transmitter through frame start and completion. It reports per-requester accept/complete pulses and a sticky error if the transmitter stalls.

## Interface
- `N_REQ`, default 4: number of requesters, 2..8.
- `TO_WIDTH`, default 22: width of the stall watchdog counter. 2^22 cycles exceeds one slowest frame (600 baud, 12 bits) at a 100 MHz clock.

- `clk`  in  1  system clock; all logic on its rising edge.
- `rst`  in  1  one clock; reset is asynchronous and active-low (`rst`=0 resets all state immediately).
- `req`  in  N_REQ  per-requester transmit request, level.
- `req_data`  in  8*N_REQ  byte of requester i on bits [8i+7:8i].
- `ack`  out  N_REQ  one-cycle pulse: requester's byte accepted (frame started).
- `done`  out  N_REQ  one-cycle pulse: requester's frame finished.
- `tx_data`  out  8  byte to transmitter, held stable for whole frame.
- `tx_send`  out  1  send request to transmitter.
- `tx_ready`  in  1  transmitter ready; asynchronous to `clk` (uartClock domain).
- `busy`  out  1  high in any state other than IDLE.
- `owner`  out  $clog2(N_REQ)  index of current or last granted requester.
- `timeout_err`  out  1  sticky watchdog error.
- `clear_err`  in  1  synchronous clear of `timeout_err`.

## Operation
- `tx_ready` passes through a 2-flop synchronizer, giving `rdy_s`; both flops reset to 0.
- FSM states: IDLE, SEND, BUSY.
- **IDLE**
  - If `rdy_s`=1 and `req`≠0, grant the first set `req` bit searching upward circularly from `ptr+1`.
  - On grant: `owner`←winner, `tx_data`←winner's byte, `tx_send`←1, go to SEND.
- **SEND**
  - Hold `tx_send`=1 and `tx_data` until `rdy_s`=0.
  - Then `tx_send`←0, `ack[owner]` pulses, go to BUSY.
- **BUSY**
  - `tx_data` is still held, because the transmitter loads it late.
  - When `rdy_s`=1: `done[owner]` pulses, `ptr`←`owner`, go to IDLE.
- **Round-robin pointer**
  - `ptr` resets to N_REQ-1, so requester 0 wins first after reset.
  - `ptr` updates only on normal completion.
- **Request sampling**
  - `req` and `req_data` are sampled only at grant.
  - Dropping `req` or changing data after grant has no effect; the frame completes.
  - A requester still asserting `req` after its `done` is re-arbitrated normally.
- **Watchdog**
  - Counter clears on entry to SEND and counts every cycle in SEND and BUSY.
  - On reaching all-ones: `timeout_err`←1, `tx_send`←0, go to IDLE.
  - On timeout: no `ack`/`done` pulse, `ptr`←`owner`.
- **Error flag**
  - `clear_err` clears `timeout_err`.
  - If a timeout and `clear_err` occur in the same cycle, set wins.
- Arbitration continues while `timeout_err`=1.

## Timing
- Reset values: `ack`=0, `done`=0, `tx_send`=0, `tx_data`=0, `busy`=0, `owner`=0, `timeout_err`=0, FSM=IDLE, `ptr`=N_REQ-1.
- All outputs are registered.
- After reset release, no grant until `rdy_s`=1, i.e. at least 2 cycles of `tx_ready`=1.
- Grant latency: `req` high at edge t (IDLE, `rdy_s`=1) gives `tx_send`/`tx_data`/`busy` valid after edge t+1.
- Ack latency: `tx_ready` falling is seen on `rdy_s` 2 edges later; `ack` and `tx_send`=0 follow 1 edge after that.
- Done latency: `tx_ready` rising gives `done` 3 edges later; IDLE is entered the same edge.
- Earliest next grant is 1 cycle after `done`, so there is a minimum 1-cycle gap with `tx_send`=0 between frames.
- At most one bit of `ack`, and at most one bit of `done`, is set in any cycle.
- `busy` falls on the same edge `done` pulses.
- Async reset mid-frame: outputs return to reset values immediately. `tx_send` drops, and the transmitter is expected to be reset with it.

## Test plan
- **Single requester:** N_REQ=4, `req`=0001, `req_data[7:0]`=0xA5, model drops `tx_ready` 5 cycles after `tx_send` and raises it 100 cycles later.
  - `tx_data`=0xA5 and `tx_send` held until `ack`=0001.
  - One `done`=0001 pulse, `owner`=0.
- **Round-robin fairness:** `req`=1111 held constantly.
  - Grants in order 0,1,2,3,0; each `ack` precedes its `done`.
  - Never two grants without an intervening `done`.
- **Pointer skip:** after requester 1 completes, set `req`=0101.
  - Next grant is 2, then 0.
- **Late withdrawal:** `req` for requester 3 drops the cycle after grant, and `req_data` changes to 0x00.
  - Frame still sent with the original byte 0x3C; `ack`/`done` for requester 3 both pulse.
- **Watchdog:** TO_WIDTH=6, model never drops `tx_ready`.
  - After 63 cycles in SEND: `timeout_err`=1, `tx_send`=0, IDLE, no `ack`.
  - Next grant goes to the following requester.
  - `clear_err` pulse then gives `timeout_err`=0.
- **Reset mid-frame:** `rst`=0 during BUSY.
  - All outputs 0 within the same cycle.
  - After release with `req`=0010 and `tx_ready`=1, first grant to requester 1 on the 3rd edge after release.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// rtl/uart_tx_arbiter.sv - round-robin arbiter sharing one uart_tx among N_REQ byte requesters
module uart_tx_arbiter #(
  parameter int N_REQ    = 4,
  parameter int TO_WIDTH = 22
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req,
  input  logic [8*N_REQ-1:0]         req_data,
  output logic [N_REQ-1:0]           ack,
  output logic [N_REQ-1:0]           done,
  output logic [7:0]                 tx_data,
  output logic                       tx_send,
  input  logic                       tx_ready,
  output logic                       busy,
  output logic [$clog2(N_REQ)-1:0]   owner,
  output logic                       timeout_err,
  input  logic                       clear_err
);

  localparam int OW = $clog2(N_REQ);
  localparam int PW = OW + 1;
  // One short of all-ones: the edge that takes the counter to all-ones is the timeout edge.
  localparam logic [TO_WIDTH-1:0] WD_LAST = {{(TO_WIDTH-1){1'b1}}, 1'b0};

  typedef enum logic [1:0] {IDLE, SEND, BUSY} state_t;

  state_t              state_q, state_d;
  logic                rdy_m, rdy_s;
  logic [OW-1:0]       ptr;
  logic [TO_WIDTH-1:0] wd_cnt;
  logic                wd_hit;
  logic [PW-1:0]       pos;
  logic                win_found;
  logic [OW-1:0]       win_idx;
  logic                grant, accept, finish, tmo;
  logic                send_d, busy_d;
  logic [N_REQ-1:0]    ack_d, done_d;

  // Bring tx_ready from the transmitter's clock domain into clk.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rdy_m <= 1'b0;
      rdy_s <= 1'b0;
    end else begin
      rdy_m <= tx_ready;
      rdy_s <= rdy_m;
    end
  end

  // Circular search from ptr+1; scanning downward lets the nearest set request win last.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    pos       = '0;
    for (int k = N_REQ; k >= 1; k--) begin
      pos = {1'b0, ptr} + PW'(k);
      if (pos >= PW'(N_REQ)) pos = pos - PW'(N_REQ);
      if (req[pos[OW-1:0]]) begin
        win_found = 1'b1;
        win_idx   = pos[OW-1:0];
      end
    end
  end

  assign wd_hit = (wd_cnt == WD_LAST);

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and frame events; transmitter progress takes priority over the watchdog.
  always_comb begin
    state_d = state_q;
    grant   = 1'b0;
    accept  = 1'b0;
    finish  = 1'b0;
    tmo     = 1'b0;
    case (state_q)
      IDLE: if (rdy_s && win_found) begin
        grant   = 1'b1;
        state_d = SEND;
      end
      SEND: if (!rdy_s) begin
        accept  = 1'b1;
        state_d = BUSY;
      end else if (wd_hit) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end
      BUSY: if (rdy_s) begin
        finish  = 1'b1;
        state_d = IDLE;
      end else if (wd_hit) begin
        tmo     = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Next values of the registered handshake and status outputs.
  always_comb begin
    send_d = (state_d == SEND);
    busy_d = (state_d != IDLE);
    ack_d  = accept ? (N_REQ'(1) << owner) : '0;
    done_d = finish ? (N_REQ'(1) << owner) : '0;
  end

  // Output registers, captured request, watchdog, pointer and sticky error.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tx_send     <= 1'b0;
      busy        <= 1'b0;
      ack         <= '0;
      done        <= '0;
      owner       <= '0;
      tx_data     <= '0;
      wd_cnt      <= '0;
      ptr         <= OW'(N_REQ - 1);
      timeout_err <= 1'b0;
    end else begin
      tx_send <= send_d;
      busy    <= busy_d;
      ack     <= ack_d;
      done    <= done_d;
      if (grant) begin
        owner   <= win_idx;
        tx_data <= req_data[{win_idx, 3'b000} +: 8];
      end
      if (grant)                 wd_cnt <= '0;
      else if (state_q != IDLE)  wd_cnt <= wd_cnt + TO_WIDTH'(1);
      if (finish || tmo) ptr <= owner;
      if (tmo)            timeout_err <= 1'b1;
      else if (clear_err) timeout_err <= 1'b0;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb/tb_uart_tx_arbiter.sv - self-checking bench for uart_tx_arbiter
module tb_uart_tx_arbiter;

  localparam int N  = 4;
  localparam int TW = 6;

  logic           clk = 1'b0;
  logic           rst = 1'b0;
  logic [N-1:0]   req = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   ack, done;
  logic [7:0]     tx_data;
  logic           tx_send;
  logic           tx_ready = 1'b0;
  logic           busy;
  logic [1:0]     owner;
  logic           timeout_err;
  logic           clear_err = 1'b0;

  int checks = 0;
  int errors = 0;
  int m_ptr  = N - 1;

  uart_tx_arbiter #(.N_REQ(N), .TO_WIDTH(TW)) dut (
    .clk(clk), .rst(rst), .req(req), .req_data(req_data), .ack(ack), .done(done),
    .tx_data(tx_data), .tx_send(tx_send), .tx_ready(tx_ready), .busy(busy),
    .owner(owner), .timeout_err(timeout_err), .clear_err(clear_err)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference arbitration: first requester found walking circularly upward from p+1.
  function automatic int rr_pick(input logic [N-1:0] r, input int p);
    int pick;
    pick = -1;
    for (int k = 1; k <= N; k++)
      if (pick < 0 && r[(p + k) % N]) pick = (p + k) % N;
    return pick;
  endfunction

  task automatic await_grant(output int w, output logic [7:0] b, output int n);
    w = rr_pick(req, m_ptr);
    if (w < 0) w = 0;
    b = req_data[8*w +: 8];
    n = 0;
    while (tx_send !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("grant_seen", tx_send, 1);
    chk("grant_owner", owner, w);
    chk("grant_data", tx_data, b);
    chk("grant_busy", busy, 1);
    chk("grant_no_ack", ack, 0);
  endtask

  task automatic complete_frame(input int w, input logic [7:0] b, input int hold);
    int n;
    bit ok;
    ok = 1;
    for (int i = 0; i < 5; i++) begin
      tick();
      if (tx_send !== 1'b1 || tx_data !== b || ack !== '0) ok = 0;
    end
    chk("send_hold", ok, 1);
    tx_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ack === '0 && n < 20);
    chk("ack_latency", n, 3);
    chk("ack_vec", ack, 1 << w);
    chk("ack_send_low", tx_send, 0);
    chk("ack_busy", busy, 1);
    ok = 1;
    for (int i = 0; i < hold; i++) begin
      tick();
      if (tx_data !== b || busy !== 1'b1 || done !== '0 || ack !== '0 || tx_send !== 1'b0) ok = 0;
    end
    chk("busy_hold", ok, 1);
    tx_ready = 1'b1;
    n = 0;
    do begin tick(); n++; end while (done === '0 && n < 20);
    chk("done_latency", n, 3);
    chk("done_vec", done, 1 << w);
    chk("done_busy_low", busy, 0);
    chk("done_owner", owner, w);
    m_ptr = w;
  endtask

  initial begin
    int w, w2, n;
    logic [7:0] b;
    bit ok;

    // Reset state and first grant after release.
    tx_ready = 1'b1;
    req      = 4'b0001;
    req_data = {$urandom()};
    req_data[7:0] = 8'hA5;
    tick();
    tick();
    chk("rst_ack", ack, 0);
    chk("rst_done", done, 0);
    chk("rst_send", tx_send, 0);
    chk("rst_data", tx_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 0);
    chk("rst_err", timeout_err, 0);
    rst = 1'b1;
    tick();
    tick();
    chk("rel_no_grant", tx_send, 0);
    tick();
    chk("rel_grant_edge3", tx_send, 1);
    await_grant(w, b, n);
    req = '0;
    complete_frame(w, b, 20);

    // Round robin with all requesting; grant follows done by exactly one cycle.
    req      = 4'hF;
    req_data = {$urandom()};
    for (int f = 0; f < 5; f++) begin
      await_grant(w, b, n);
      chk("rr_gap", n, 1);
      complete_frame(w, b, $urandom_range(8, 30));
    end

    // Pointer skip after requester 1 completes.
    req = 4'b0101;
    for (int f = 0; f < 2; f++) begin
      await_grant(w, b, n);
      complete_frame(w, b, $urandom_range(8, 30));
    end
    req = '0;

    // Late withdrawal: request and data change right after grant.
    req = 4'b1000;
    req_data[31:24] = 8'h3C;
    await_grant(w, b, n);
    req      = '0;
    req_data = '0;
    complete_frame(w, b, 15);

    // Randomized requests and bytes, changed after every grant.
    for (int f = 0; f < 10; f++) begin
      if (req == '0) req = N'($urandom_range(1, 15));
      req_data = {$urandom()};
      await_grant(w, b, n);
      req      = N'($urandom_range(0, 15));
      req_data = {$urandom()};
      complete_frame(w, b, $urandom_range(8, 30));
    end
    req = '0;
    tick();

    // Watchdog: transmitter never drops ready.
    req = N'($urandom_range(1, 15));
    await_grant(w, b, n);
    req = '0;
    n = 0;
    ok = 1;
    while (tx_send === 1'b1 && n < 200) begin
      tick();
      n++;
      if (ack !== '0 || done !== '0) ok = 0;
    end
    chk("wd_latency", n, 63);
    chk("wd_err", timeout_err, 1);
    chk("wd_busy_low", busy, 0);
    chk("wd_no_pulse", ok, 1);
    m_ptr = w;

    // Next grant goes to the following requester; set wins over a held clear.
    req = 4'hF;
    await_grant(w2, b, n);
    chk("wd_next_owner", w2, (w + 1) % N);
    chk("wd_next_gap", n, 1);
    req       = '0;
    clear_err = 1'b1;
    tick();
    chk("clr_applied", timeout_err, 0);
    n = 1;
    while (tx_send === 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("wd2_latency", n, 63);
    chk("wd_set_wins", timeout_err, 1);
    m_ptr = w2;
    clear_err = 1'b0;
    tick();
    chk("err_sticky", timeout_err, 1);
    clear_err = 1'b1;
    tick();
    clear_err = 1'b0;
    chk("err_cleared", timeout_err, 0);

    // Asynchronous reset while BUSY.
    req = 4'b0100;
    await_grant(w, b, n);
    req = '0;
    repeat (5) tick();
    tx_ready = 1'b0;
    n = 0;
    do begin tick(); n++; end while (ack === '0 && n < 20);
    chk("mid_ack", ack, 1 << w);
    repeat (4) tick();
    rst = 1'b0;
    #1;
    chk("mid_rst_send", tx_send, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_owner", owner, 0);
    chk("mid_rst_data", tx_data, 0);
    chk("mid_rst_ackdone", {ack, done}, 0);
    chk("mid_rst_err", timeout_err, 0);
    m_ptr    = N - 1;
    tx_ready = 1'b1;
    req      = 4'b0010;
    tick();
    rst = 1'b1;
    tick();
    tick();
    chk("rel2_no_grant", tx_send, 0);
    tick();
    chk("rel2_grant_edge3", tx_send, 1);
    await_grant(w, b, n);
    chk("rel2_owner", w, 1);
    req = '0;
    complete_frame(w, b, 10);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
